// File: rtl/io_pattern_tester.sv
// Per-pad GPIO exerciser over the pad window [BASE_PIN, BASE_PIN+NUM_CH-1].
// Optional PRBS mode is enabled by defining IO_TESTER_PRBS_EN; otherwise mode 5 acts as INPUT.
`ifndef MPRJ_IO_PADS
`define MPRJ_IO_PADS 38
`endif

module io_pattern_tester #(
    parameter int NUM_CH   = 7,
    parameter int BASE_PIN = 8,
    parameter int DIV_W    = 8,
    parameter int CNT_W    = 16,
    parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [2:0]               cfg_mode,
    input  logic [DIV_W-1:0]         cfg_div,
    input  logic [CH_W-1:0]          rd_ch,
    output logic [CNT_W-1:0]         rd_count,
    input  logic [`MPRJ_IO_PADS-1:0] io_in,
    output logic [`MPRJ_IO_PADS-1:0] io_out,
    output logic [`MPRJ_IO_PADS-1:0] io_oeb
);

    typedef enum logic [2:0] {
        M_INPUT = 3'd0,
        M_LOW   = 3'd1,
        M_HIGH  = 3'd2,
        M_CLOCK = 3'd3,
        M_DIV   = 3'd4,
        M_PRBS  = 3'd5,
        M_LOOP  = 3'd6,
        M_EDGE  = 3'd7
    } mode_e;

    logic [NUM_CH-1:0] w_pad_in;
    logic [NUM_CH-1:0] r_s1, r_s2, r_s3;
    logic [NUM_CH-1:0] w_ch_out, w_ch_oeb;
    logic [CNT_W-1:0]  w_cnt [2**CH_W];
    logic              w_unused_io;

    assign w_pad_in    = io_in[BASE_PIN +: NUM_CH];
    assign w_unused_io = ^io_in;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= w_pad_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

`ifdef IO_TESTER_PRBS_EN
    // x^7 + x^6 + 1, maximal length (127)
    logic [6:0] r_lfsr;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_lfsr <= 7'h01;
        else          r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
    end
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam int             CI      = c;
        localparam logic [CH_W-1:0] CIDX   = CI[CH_W-1:0];
        localparam int             PARTNER = c ^ 1;
`ifdef IO_TESTER_PRBS_EN
        localparam int             LBIT    = c % 7;
`endif

        mode_e            r_mode;
        logic [DIV_W-1:0] r_div, r_dcnt;
        logic             r_tog;
        logic [CNT_W-1:0] r_cnt;
        logic             r_out, r_oeb, r_clk;
        logic             w_wr, w_lb;

        assign w_wr = cfg_we && (cfg_ch == CIDX);

        if (PARTNER < NUM_CH) begin : g_lb
            assign w_lb = r_s2[PARTNER];
        end else begin : g_nolb
            assign w_lb = 1'b0;
        end

        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                r_mode <= M_INPUT;
                r_div  <= '0;
                r_dcnt <= '0;
                r_tog  <= 1'b0;
                r_cnt  <= '0;
                r_out  <= 1'b0;
                r_oeb  <= 1'b1;
                r_clk  <= 1'b0;
            end else begin
                // Pad registers follow the mode held before this edge, so a new mode shows one cycle later.
                r_clk <= (r_mode == M_CLOCK);
                case (r_mode)
                    M_INPUT: begin r_out <= 1'b0;  r_oeb <= 1'b1; end
                    M_LOW:   begin r_out <= 1'b0;  r_oeb <= 1'b0; end
                    M_HIGH:  begin r_out <= 1'b1;  r_oeb <= 1'b0; end
                    M_CLOCK: begin r_out <= 1'b0;  r_oeb <= 1'b0; end
                    M_DIV:   begin r_out <= r_tog; r_oeb <= 1'b0; end
`ifdef IO_TESTER_PRBS_EN
                    M_PRBS:  begin r_out <= r_lfsr[LBIT]; r_oeb <= 1'b0; end
`else
                    M_PRBS:  begin r_out <= 1'b0;  r_oeb <= 1'b1; end
`endif
                    M_LOOP:  begin r_out <= w_lb;  r_oeb <= 1'b0; end
                    M_EDGE:  begin r_out <= 1'b0;  r_oeb <= 1'b1; end
                endcase

                if (w_wr) begin
                    r_mode <= mode_e'(cfg_mode);
                    r_div  <= cfg_div;
                    r_dcnt <= '0;
                    r_tog  <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    if (r_mode == M_DIV) begin
                        if (r_dcnt == r_div) begin
                            r_dcnt <= '0;
                            r_tog  <= ~r_tog;
                        end else begin
                            r_dcnt <= r_dcnt + DIV_W'(1);
                        end
                    end
                    // Saturating rising-edge count on the synchronised input.
                    if (r_mode == M_EDGE && r_s2[c] && !r_s3[c] && r_cnt != {CNT_W{1'b1}})
                        r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end

        assign w_ch_out[c] = r_clk ? wb_clk_i : r_out;
        assign w_ch_oeb[c] = r_oeb;
        assign w_cnt[c]    = r_cnt;
    end

    // Unpopulated read slots return zero.
    for (genvar c = NUM_CH; c < 2**CH_W; c++) begin : g_pad
        assign w_cnt[c] = '0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) rd_count <= '0;
        else          rd_count <= w_cnt[rd_ch];
    end

    always_comb begin
        io_out = '0;
        io_oeb = '1;
        io_out[BASE_PIN +: NUM_CH] = w_ch_out;
        io_oeb[BASE_PIN +: NUM_CH] = w_ch_oeb;
    end

endmodule
